// File: rtl/ps2_key_event.sv
// Turns PS/2 scan-code bytes into {code, ext, release} key events and queues them in a FWFT FIFO.
// Define PS2_TYPEMATIC_FILTER_EN to suppress typematic repeats of a held key.
module ps2_key_event #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        byte_valid,
    input  logic [7:0]                  byte_data,
    input  logic                        byte_error,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [7:0]                  evt_code,
    output logic                        evt_ext,
    output logic                        evt_release,
    output logic [$clog2(FIFO_DEPTH):0] evt_count,
    output logic                        err_drop,
    output logic                        overflow
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StE0, StF0, StE0F0} state_e;

    state_e          state_q;
    logic [TW-1:0]   tmo_q;
    logic [9:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;

    logic is_e0, is_f0, is_ctrl;
    logic emit, new_ext, new_rel, suppress;
    logic push_req, push_ok, pop, full;

    always_comb begin
        is_e0   = (byte_data == 8'hE0);
        is_f0   = (byte_data == 8'hF0);
        is_ctrl = 1'b0;
        case (byte_data)
            8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_ctrl = 1'b1;
            default:                                                        is_ctrl = 1'b0;
        endcase
        emit    = byte_valid & ~byte_error & ~is_ctrl & ~is_e0 & ~is_f0;
        new_ext = (state_q == StE0) || (state_q == StE0F0);
        new_rel = (state_q == StF0) || (state_q == StE0F0);
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [8:0] last_make_q;
    logic       held_q;

    assign suppress = emit & ~new_rel & held_q & (last_make_q == {new_ext, byte_data});

    always_ff @(posedge clk) begin
        if (rst) begin
            last_make_q <= '0;
            held_q      <= 1'b0;
        end else if (push_req) begin
            if (!new_rel) begin
                last_make_q <= {new_ext, byte_data};
                held_q      <= 1'b1;
            end else if (last_make_q == {new_ext, byte_data}) begin
                held_q      <= 1'b0;
            end
        end
    end
`else
    assign suppress = 1'b0;
`endif

    assign push_req = emit & ~suppress;
    assign full     = (count_q == CNT_FULL);
    assign pop      = evt_valid & evt_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok  = push_req & (~full | pop);

    // Prefix FSM with abandon timer; the timer only runs while a prefix is pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            tmo_q    <= '0;
            err_drop <= 1'b0;
        end else begin
            err_drop <= byte_valid & byte_error;
            if (byte_valid) begin
                tmo_q <= '0;
                if (byte_error || is_ctrl) begin
                    state_q <= StIdle;
                end else if (is_e0) begin
                    state_q <= StE0;
                end else if (is_f0) begin
                    if (state_q == StIdle)    state_q <= StF0;
                    else if (state_q == StE0) state_q <= StE0F0;
                end else begin
                    state_q <= StIdle;
                end
            end else if (state_q == StIdle) begin
                tmo_q <= '0;
            end else if (tmo_q == TMO_LAST) begin
                state_q <= StIdle;
                tmo_q   <= '0;
            end else begin
                tmo_q <= tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= {new_ext, new_rel, byte_data};
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_ok && !pop)      count_q <= count_q + (AW + 1)'(1);
            else if (!push_ok && pop) count_q <= count_q - (AW + 1)'(1);
            if (push_req && full && !pop) overflow <= 1'b1;
        end
    end

    assign evt_valid                          = (count_q != '0);
    assign evt_count                          = count_q;
    assign {evt_ext, evt_release, evt_code}   = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_ps2_key_event.sv
// Directed bench for ps2_key_event: vector table for prefix decoding plus hand sequences
// for timeout boundary, overflow/drain, reset and typematic behaviour.
module tb_ps2_key_event;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_error = 1'b0;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_release;
    logic [3:0] evt_count;
    logic       err_drop;
    logic       overflow;

    int total = 0;
    int bad = 0;

    ps2_key_event #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_error (byte_error),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_ext    (evt_ext),
        .evt_release(evt_release),
        .evt_count  (evt_count),
        .err_drop   (err_drop),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       bv;
        logic [7:0] bd;
        logic       be;
        logic       ev;
        logic [7:0] ec;
        logic       ee;
        logic       er;
        int         cnt;
        logic       ed;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic bv, logic [7:0] bd, logic be, logic ev, logic [7:0] ec,
                                logic ee, logic er, int cnt, logic ed);
        vec_t v;
        v = '{bv, bd, be, ev, ec, ee, er, cnt, ed};
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic e, input logic r);
        byte_valid = v;
        byte_data  = d;
        byte_error = e;
        evt_ready  = r;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        byte_error = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_code [8];
        logic [7:0] tm_code [5];
        logic       tm_rel [5];
        int         tm_n;

        do_reset();
        chk("rst_valid", evt_valid, 0);
        chk("rst_count", evt_count, 0);
        chk("rst_err_drop", err_drop, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_code", evt_code, 0);
        chk("rst_ext", evt_ext, 0);
        chk("rst_release", evt_release, 0);

        // Table: evt_ready held high, so each event is popped the cycle after it appears.
        add(1, 8'h1C, 0, 1, 8'h1C, 0, 0, 1, 0);
        add(1, 8'hF0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(1, 8'h1C, 0, 1, 8'h1C, 0, 1, 1, 0);
        add(1, 8'hE0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(1, 8'h75, 0, 1, 8'h75, 1, 0, 1, 0);
        add(1, 8'hE0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(1, 8'hF0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(1, 8'h75, 0, 1, 8'h75, 1, 1, 1, 0);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
        add(1, 8'hE0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(1, 8'h34, 1, 0, 8'h00, 0, 0, 0, 1);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
        add(1, 8'h34, 0, 1, 8'h34, 0, 0, 1, 0);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
        add(1, 8'hE0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(1, 8'hAA, 0, 0, 8'h00, 0, 0, 0, 0);
        add(1, 8'hFA, 0, 0, 8'h00, 0, 0, 0, 0);
        add(1, 8'hE1, 0, 0, 8'h00, 0, 0, 0, 0);
        add(1, 8'h6B, 0, 1, 8'h6B, 0, 0, 1, 0);
        add(1, 8'hF0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(1, 8'hF0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(1, 8'h1C, 0, 1, 8'h1C, 0, 1, 1, 0);
        add(1, 8'hE0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(1, 8'hF0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(1, 8'hE0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(1, 8'h1C, 0, 1, 8'h1C, 1, 0, 1, 0);
        add(1, 8'hF0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(1, 8'hE0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(1, 8'h1C, 0, 1, 8'h1C, 1, 0, 1, 0);
        add(1, 8'hE0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
        add(1, 8'h5A, 0, 1, 8'h5A, 0, 0, 1, 0);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].bv, vecs[i].bd, vecs[i].be, 1'b1);
            chk($sformatf("vec%0d_valid", i), evt_valid, vecs[i].ev);
            chk($sformatf("vec%0d_count", i), evt_count, vecs[i].cnt);
            chk($sformatf("vec%0d_err_drop", i), err_drop, vecs[i].ed);
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d_code", i), evt_code, vecs[i].ec);
                chk($sformatf("vec%0d_ext", i), evt_ext, vecs[i].ee);
                chk($sformatf("vec%0d_rel", i), evt_release, vecs[i].er);
            end
        end

        // Timeout boundary: 15 idle cycles keep F0 pending, 16 abandon it.
        step(1, 8'hF0, 0, 1);
        for (int k = 0; k < 15; k++) step(0, 8'h00, 0, 1);
        step(1, 8'h1C, 0, 1);
        chk("tmo15_valid", evt_valid, 1);
        chk("tmo15_rel", evt_release, 1);
        step(0, 8'h00, 0, 1);
        step(1, 8'hF0, 0, 1);
        for (int k = 0; k < 16; k++) step(0, 8'h00, 0, 1);
        step(1, 8'h1C, 0, 1);
        chk("tmo16_valid", evt_valid, 1);
        chk("tmo16_code", evt_code, 8'h1C);
        chk("tmo16_rel", evt_release, 0);
        step(0, 8'h00, 0, 1);

        // Overflow: 9 makes into 8 entries with no consumer.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(1, 8'(8'h15 + i), 0, 0);
            chk($sformatf("ovf_count%0d", i), evt_count, (i < 8) ? i + 1 : 8);
            chk($sformatf("ovf_flag%0d", i), overflow, (i == 8) ? 1 : 0);
        end
        chk("ovf_head", evt_code, 8'h15);
        step(1, 8'h2A, 0, 1);
        chk("full_pushpop_count", evt_count, 8);
        chk("full_pushpop_ovf", overflow, 1);
        for (int i = 0; i < 7; i++) exp_code[i] = 8'(8'h16 + i);
        exp_code[7] = 8'h2A;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_code%0d", i), evt_code, exp_code[i]);
            chk($sformatf("drain_count%0d", i), evt_count, 8 - i);
            step(0, 8'h00, 0, 1);
        end
        chk("drain_empty", evt_valid, 0);
        chk("ovf_sticky", overflow, 1);

        // Reset mid-sequence drops queued events and the pending prefix.
        step(1, 8'h5A, 0, 0);
        step(1, 8'hE0, 0, 0);
        do_reset();
        chk("midrst_count", evt_count, 0);
        chk("midrst_ovf", overflow, 0);
        step(1, 8'h1C, 0, 0);
        chk("midrst_code", evt_code, 8'h1C);
        chk("midrst_ext", evt_ext, 0);
        chk("midrst_count1", evt_count, 1);

        // Typematic sequence: 1C 1C 1C F0 1C 1C.
        do_reset();
        step(1, 8'h1C, 0, 0);
        step(1, 8'h1C, 0, 0);
        step(1, 8'h1C, 0, 0);
        step(1, 8'hF0, 0, 0);
        step(1, 8'h1C, 0, 0);
        step(1, 8'h1C, 0, 0);
`ifdef PS2_TYPEMATIC_FILTER_EN
        tm_n = 3;
        tm_rel[0] = 0; tm_rel[1] = 1; tm_rel[2] = 0; tm_rel[3] = 0; tm_rel[4] = 0;
`else
        tm_n = 5;
        tm_rel[0] = 0; tm_rel[1] = 0; tm_rel[2] = 0; tm_rel[3] = 1; tm_rel[4] = 0;
`endif
        for (int i = 0; i < 5; i++) tm_code[i] = 8'h1C;
        chk("tm_count", evt_count, tm_n);
        for (int i = 0; i < tm_n; i++) begin
            chk($sformatf("tm_code%0d", i), evt_code, tm_code[i]);
            chk($sformatf("tm_rel%0d", i), evt_release, tm_rel[i]);
            step(0, 8'h00, 0, 1);
        end
        chk("tm_empty", evt_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
